timer_irq_source: RTL and testbench

- Game Boy DIV/TIMA/TMA/TAC timer (FF04–FF07).
- Requester end of the peripheral interrupt handshake: holds int_req high on TIMA overflow until the interrupt controller returns a one-cycle int_ack pulse.
- Its int_req output drives bit 2 (TIMER) of the controller's request vector; the controller's int_ack[2] returns here.
- Sits on the shared CPU I/O bus with the same cs/A/Di/Do/wr_n/rd_n protocol as the other register blocks.

---
 rtl/timer_irq_source.sv | 154 +++++++++++++++
 tb/tb_timer_irq_source.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_source.sv
// Game Boy DIV/TIMA/TMA/TAC timer block (FF04-FF07) with a level interrupt
// request that stays asserted until the interrupt controller acknowledges it.
module timer_irq_source #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] A,
  input  logic [7:0]  Di,
  output logic [7:0]  Do,
  input  logic        wr_n,
  input  logic        rd_n,
  input  logic        cs,
  output logic        int_req,
  input  logic        int_ack
);

  localparam int unsigned PW   = 8;
  localparam int unsigned DW   = 16;
  localparam int unsigned RW   = 8;
  localparam int unsigned TACW = 3;

  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  localparam logic [15:0] ADDR_DIV  = 16'hFF04;
  localparam logic [15:0] ADDR_TIMA = 16'hFF05;
  localparam logic [15:0] ADDR_TMA  = 16'hFF06;
  localparam logic [15:0] ADDR_TAC  = 16'hFF07;

  logic [PW-1:0]   presc_q,   presc_d;
  logic [DW-1:0]   div_q,     div_d;
  logic [RW-1:0]   tima_q,    tima_d;
  logic [RW-1:0]   tma_q,     tma_d;
  logic [TACW-1:0] tac_q,     tac_d;
  logic            sig_q,     sig_d;
  logic            int_req_q, int_req_d;
  logic [RW-1:0]   reg_out_q, reg_out_d;

  logic tick;
  logic wr_en, rd_en;
  logic wr_div, wr_tima, wr_tma, wr_tac;
  logic sel_bit;
  logic sig_now;
  logic sig_fall;
  logic tima_full;
  logic overflow;

  // Bus strobe decode; a write strobe masks a simultaneous read strobe
  always_comb begin
    wr_en   = cs & ~wr_n;
    rd_en   = cs & wr_n & ~rd_n;
    wr_div  = wr_en && (A == ADDR_DIV);
    wr_tima = wr_en && (A == ADDR_TIMA);
    wr_tma  = wr_en && (A == ADDR_TMA);
    wr_tac  = wr_en && (A == ADDR_TAC);
  end

  // Prescaler and free-running divider
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
    if (wr_div) begin
      div_d = '0;
    end else if (tick) begin
      div_d = div_q + DW'(1);
    end else begin
      div_d = div_q;
    end
  end

  // Timer input select and falling-edge detect; DIV/TAC writes can create edges
  always_comb begin
    sel_bit = 1'b0;
    case (tac_q[1:0])
      2'b00:   sel_bit = div_q[9];
      2'b01:   sel_bit = div_q[3];
      2'b10:   sel_bit = div_q[5];
      2'b11:   sel_bit = div_q[7];
      default: sel_bit = 1'b0;
    endcase
    sig_now  = tac_q[2] & sel_bit;
    sig_d    = sig_now;
    sig_fall = sig_q & ~sig_now;
  end

  // TIMA/TMA/TAC update; CPU writes to TIMA beat the increment and reload
  always_comb begin
    tma_d     = wr_tma ? Di : tma_q;
    tac_d     = wr_tac ? Di[TACW-1:0] : tac_q;
    tima_full = (tima_q == 8'hFF);
    overflow  = sig_fall & tima_full & ~wr_tima;
    tima_d    = tima_q;
    if (wr_tima) begin
      tima_d = Di;
    end else if (sig_fall) begin
      // Reload sees a coincident TMA write through tma_d
      tima_d = tima_full ? tma_d : tima_q + RW'(1);
    end
  end

  // Interrupt request: a fresh overflow wins over a coincident acknowledge
  always_comb begin
    int_req_d = int_req_q;
    if (overflow) begin
      int_req_d = 1'b1;
    end else if (int_ack) begin
      int_req_d = 1'b0;
    end
  end

  // Registered read data; unmapped addresses hold the previous value
  always_comb begin
    reg_out_d = reg_out_q;
    if (rd_en) begin
      case (A)
        ADDR_DIV:  reg_out_d = div_q[15:8];
        ADDR_TIMA: reg_out_d = tima_q;
        ADDR_TMA:  reg_out_d = tma_q;
        ADDR_TAC:  reg_out_d = {5'b11111, tac_q};
        default:   reg_out_d = reg_out_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= '0;
      div_q     <= '0;
      tima_q    <= '0;
      tma_q     <= '0;
      tac_q     <= '0;
      sig_q     <= 1'b0;
      int_req_q <= 1'b0;
      reg_out_q <= '0;
    end else begin
      presc_q   <= presc_d;
      div_q     <= div_d;
      tima_q    <= tima_d;
      tma_q     <= tma_d;
      tac_q     <= tac_d;
      sig_q     <= sig_d;
      int_req_q <= int_req_d;
      reg_out_q <= reg_out_d;
    end
  end

  // Output drive; the data bus floats high when not selected
  always_comb begin
    Do      = cs ? reg_out_q : 8'hFF;
    int_req = int_req_q;
  end

endmodule

// File: tb/tb_timer_irq_source.sv
// Directed bench for timer_irq_source: reset, DIV, overflow/reload timing,
// interrupt handshake, write priority, TMA bypass, edge glitches, prescaler.
module tb_timer_irq_source;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] A;
  logic [7:0]  Di;
  logic [7:0]  Do;
  logic        wr_n, rd_n, cs, int_ack;
  logic        int_req;

  logic [15:0] A2;
  logic [7:0]  Di2;
  logic [7:0]  Do2;
  logic        wr2_n, rd2_n, cs2, ack2;
  logic        int_req2;

  int   cyc;
  int   checks   = 0;
  int   failures = 0;
  logic done2    = 1'b0;
  int   t, x;
  logic [7:0] rd;

  timer_irq_source #(.PRESCALE(1)) dut (
    .clock(clock), .reset_n(reset_n), .A(A), .Di(Di), .Do(Do),
    .wr_n(wr_n), .rd_n(rd_n), .cs(cs), .int_req(int_req), .int_ack(int_ack)
  );

  timer_irq_source #(.PRESCALE(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .A(A2), .Di(Di2), .Do(Do2),
    .wr_n(wr2_n), .rd_n(rd2_n), .cs(cs2), .int_req(int_req2), .int_ack(ack2)
  );

  always #5 clock = ~clock;

  // Rising edges since the last reset release
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clock);
    cs = 1'b1; A = addr; Di = data; wr_n = 1'b0;
    @(posedge clock);
    #1;
    wr_n = 1'b1; cs = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] addr, output logic [7:0] data);
    @(negedge clock);
    cs = 1'b1; A = addr; rd_n = 1'b0;
    @(posedge clock);
    #1;
    data = Do;
    rd_n = 1'b1; cs = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clock);
    int_ack = 1'b1;
    @(posedge clock);
    #1;
    int_ack = 1'b0;
  endtask

  // Advance to 1 time unit after rising edge number n
  task automatic wait_cyc(input int n);
    if (cyc > n) chk("sched_late", 16'(cyc), 16'(n));
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Prescaled instance: DIV advances once per 4 clocks
  initial begin
    cs2 = 1'b0; wr2_n = 1'b1; rd2_n = 1'b1; A2 = '0; Di2 = '0; ack2 = 1'b0;
    @(posedge reset_n);
    while (cyc < 1023) begin
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    cs2 = 1'b1; A2 = 16'hFF04; rd2_n = 1'b0;
    @(posedge clock);
    #1;
    chk("p4_div_1024", 16'(Do2), 16'h00);
    @(posedge clock);
    #1;
    chk("p4_div_1025", 16'(Do2), 16'h01);
    cs2 = 1'b0; rd2_n = 1'b1;
    #1;
    chk("p4_do_idle", 16'(Do2), 16'hFF);
    chk("p4_int_req", 16'(int_req2), 16'h0);
    done2 = 1'b1;
  end

  initial begin
    reset_n = 1'b0; cs = 1'b0; wr_n = 1'b1; rd_n = 1'b1;
    A = '0; Di = '0; int_ack = 1'b0;
    #12;
    chk("rst_int_req", 16'(int_req), 16'h0);
    chk("rst_do_idle", 16'(Do), 16'hFF);
    cs = 1'b1; A = 16'hFF05;
    #1;
    chk("rst_reg_out", 16'(Do), 16'h00);
    cs = 1'b0;
    #10;
    reset_n = 1'b1;

    bus_rd(16'hFF07, rd); chk("rst_tac", 16'(rd), 16'hF8);
    // Read latency: old data before the edge, new data after
    @(negedge clock);
    cs = 1'b1; A = 16'hFF05; rd_n = 1'b0;
    #1;
    chk("rd_latency_old", 16'(Do), 16'hF8);
    @(posedge clock);
    #1;
    chk("rst_tima", 16'(Do), 16'h00);
    rd_n = 1'b1; cs = 1'b0;

    // DIV counts from reset
    wait_cyc(512);
    bus_rd(16'hFF04, rd); chk("div_512", 16'(rd), 16'h02);
    bus_wr(16'hFF04, 8'h5A);
    bus_rd(16'hFF04, rd); chk("div_cleared", 16'(rd), 16'h00);
    bus_rd(16'hFF05, rd); chk("tima_idle", 16'(rd), 16'h00);

    // Overflow timing with /16 source
    bus_wr(16'hFF06, 8'h80);
    bus_wr(16'hFF05, 8'hFE);
    bus_wr(16'hFF04, 8'h00);
    bus_wr(16'hFF07, 8'h05);
    t = cyc;
    wait_cyc(t + 16);
    chk("inc1_int_req", 16'(int_req), 16'h0);
    bus_rd(16'hFF05, rd); chk("inc1_tima", 16'(rd), 16'hFF);
    wait_cyc(t + 31);
    chk("pre_ovf_int_req", 16'(int_req), 16'h0);
    wait_cyc(t + 32);
    chk("ovf_int_req", 16'(int_req), 16'h1);
    bus_rd(16'hFF05, rd); chk("ovf_reload", 16'(rd), 16'h80);

    // Handshake
    wait_cyc(t + 35);
    ack_pulse();
    chk("ack_clears", 16'(int_req), 16'h0);
    ack_pulse();
    chk("ack_idle", 16'(int_req), 16'h0);

    bus_wr(16'hFF05, 8'hFF);
    wait_cyc(t + 48);
    chk("ovf2_int_req", 16'(int_req), 16'h1);
    bus_rd(16'hFF05, rd); chk("ovf2_reload", 16'(rd), 16'h80);
    bus_wr(16'hFF05, 8'hFF);
    wait_cyc(t + 63);
    ack_pulse();
    chk("ack_vs_ovf", 16'(int_req), 16'h1);
    bus_rd(16'hFF05, rd); chk("ovf3_reload", 16'(rd), 16'h80);
    ack_pulse();
    chk("ack_clears2", 16'(int_req), 16'h0);

    // TIMA write beats a coincident overflow
    bus_wr(16'hFF05, 8'hFF);
    wait_cyc(t + 79);
    bus_wr(16'hFF05, 8'h42);
    chk("wr_prio_int_req", 16'(int_req), 16'h0);
    bus_rd(16'hFF05, rd); chk("wr_prio_tima", 16'(rd), 16'h42);

    // TMA write coincident with overflow is reloaded directly
    bus_wr(16'hFF05, 8'hFF);
    wait_cyc(t + 95);
    bus_wr(16'hFF06, 8'hC3);
    chk("bypass_int_req", 16'(int_req), 16'h1);
    bus_rd(16'hFF05, rd); chk("bypass_tima", 16'(rd), 16'hC3);
    bus_rd(16'hFF06, rd); chk("bypass_tma", 16'(rd), 16'hC3);
    ack_pulse();
    chk("ack_clears3", 16'(int_req), 16'h0);
    bus_wr(16'hFF07, 8'h00);

    // DIV write glitch with /256 source
    bus_wr(16'hFF07, 8'h07);
    bus_wr(16'hFF04, 8'h00);
    x = cyc;
    bus_wr(16'hFF05, 8'h10);
    wait_cyc(x + 129);
    bus_wr(16'hFF04, 8'h00);
    wait_cyc(x + 131);
    bus_rd(16'hFF05, rd); chk("div_glitch", 16'(rd), 16'h11);

    // TAC disable glitch
    bus_wr(16'hFF04, 8'h00);
    x = cyc;
    bus_wr(16'hFF05, 8'h10);
    wait_cyc(x + 129);
    bus_wr(16'hFF07, 8'h03);
    wait_cyc(x + 131);
    bus_rd(16'hFF05, rd); chk("tac_glitch", 16'(rd), 16'h11);
    repeat (260) @(posedge clock);
    #1;
    bus_rd(16'hFF05, rd); chk("tac_disabled", 16'(rd), 16'h11);
    bus_rd(16'hFF07, rd); chk("tac_read", 16'(rd), 16'hFB);

    // Reset during a pending request
    for (int i = 0; i < 4000 && !done2; i++) @(posedge clock);
    chk("p4_done", 16'(done2), 16'h1);
    bus_wr(16'hFF06, 8'h00);
    bus_wr(16'hFF05, 8'hFF);
    bus_wr(16'hFF07, 8'h05);
    for (int i = 0; i < 40 && !int_req; i++) @(posedge clock);
    #3;
    chk("mid_int_req", 16'(int_req), 16'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_int_req", 16'(int_req), 16'h0);
    cs = 1'b1; A = 16'hFF05;
    #1;
    chk("mid_rst_reg_out", 16'(Do), 16'h00);
    cs = 1'b0;
    #1;
    chk("mid_rst_do_idle", 16'(Do), 16'hFF);
    @(negedge clock);
    reset_n = 1'b1;
    bus_rd(16'hFF07, rd); chk("mid_rst_tac", 16'(rd), 16'hF8);
    bus_rd(16'hFF05, rd); chk("mid_rst_tima", 16'(rd), 16'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
